// File: rtl/ext_arbiter.sv
// Two-requester round-robin front end sharing one zero/sign-extension datapath.
// Holds one result in a single RESP slot; a new request reloads it in the cycle the old one leaves.
module ext_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    input  logic [2:0]        srcw0,
    input  logic              mode0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    input  logic [2:0]        srcw1,
    input  logic              mode1,
    output logic              ack0,
    output logic              ack1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_id,
    output logic [7:0]        stall_cnt
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t            state_reg, state_next;
    logic              last_grant_reg;
    logic [DATA_W-1:0] rsp_data_reg;
    logic              rsp_id_reg;
    logic [7:0]        stall_cnt_reg;

    logic              can_load;
    logic              load;
    logic [DATA_W-1:0] sel_data;
    logic [2:0]        sel_srcw;
    logic              sel_mode;
    logic [DATA_W-1:0] ext_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Round-robin: on contention the requester not granted last time wins.
    always_comb begin
        state_next = state_reg;
        can_load   = (state_reg == IDLE) || rsp_ready;
        ack0       = !rst && can_load && req0 && (!req1 || last_grant_reg);
        ack1       = !rst && can_load && req1 && (!req0 || !last_grant_reg);
        load       = ack0 || ack1;
        case (state_reg)
            IDLE: if (load) state_next = RESP;
            RESP: if (rsp_ready && !load) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign sel_data = ack1 ? data1 : data0;
    assign sel_srcw = ack1 ? srcw1 : srcw0;
    assign sel_mode = ack1 ? mode1 : mode0;

    // Bits above the source width come from the sign bit (mode 1) or zero.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_ext
            assign ext_data[gi] = (int'(sel_srcw) >= gi) ? sel_data[gi]
                                                         : (sel_mode & sel_data[sel_srcw]);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg <= 1'b1;
            rsp_data_reg   <= '0;
            rsp_id_reg     <= 1'b0;
            stall_cnt_reg  <= 8'd0;
        end else begin
            if (load) begin
                last_grant_reg <= ack1;
                rsp_data_reg   <= ext_data;
                rsp_id_reg     <= ack1;
            end
            if (state_reg == RESP && !rsp_ready && stall_cnt_reg != 8'hFF) begin
                stall_cnt_reg <= stall_cnt_reg + 8'd1;
            end
        end
    end

    assign rsp_valid = (state_reg == RESP);
    assign rsp_data  = rsp_data_reg;
    assign rsp_id    = rsp_id_reg;
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_ext_arbiter.sv
// Bench for ext_arbiter: vector table, directed corner sequences and randomized traffic,
// all checked against a transaction-level model of the arbiter kept here.
module tb_ext_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, mode0, mode1, rsp_ready;
    logic [7:0] data0, data1;
    logic [2:0] srcw0, srcw1;
    logic       ack0, ack1, rsp_valid, rsp_id;
    logic [7:0] rsp_data, stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    bit       m_valid;
    bit [7:0] m_data;
    bit       m_id;
    bit       m_last;
    int       m_stall;
    bit       e_ack0, e_ack1;

    always #5 clk = ~clk;

    ext_arbiter #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .srcw0(srcw0), .mode0(mode0),
        .req1(req1), .data1(data1), .srcw1(srcw1), .mode1(mode1),
        .ack0(ack0), .ack1(ack1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [7:0] ref_ext(input bit [7:0] d, input int w, input bit m);
        int mask = (1 << (w + 1)) - 1;
        int v    = int'(d) & mask;
        if (m && ((int'(d) >> w) & 1) == 1) v = v | (~mask & 255);
        return v[7:0];
    endfunction

    function automatic void model_reset();
        m_valid = 0; m_data = 0; m_id = 0; m_last = 1; m_stall = 0;
    endfunction

    // Called just after a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        bit can, got;
        int g;
        #1;
        can = !m_valid || rsp_ready;
        g = -1;
        if (can) begin
            if (req0 && req1) g = m_last ? 0 : 1;
            else if (req0)    g = 0;
            else if (req1)    g = 1;
        end
        e_ack0 = (g == 0);
        e_ack1 = (g == 1);
        chk("ack0", int'(ack0), int'(e_ack0));
        chk("ack1", int'(ack1), int'(e_ack1));
        chk("rsp_valid", int'(rsp_valid), int'(m_valid));
        chk("stall_cnt", int'(stall_cnt), m_stall);
        if (m_valid) begin
            chk("rsp_data", int'(rsp_data), int'(m_data));
            chk("rsp_id", int'(rsp_id), int'(m_id));
        end
        if (m_valid && !rsp_ready && m_stall < 255) m_stall++;
        got = (g >= 0);
        if (got) begin
            m_data  = (g == 1) ? ref_ext(data1, int'(srcw1), mode1) : ref_ext(data0, int'(srcw0), mode0);
            m_id    = (g == 1);
            m_last  = (g == 1);
            m_valid = 1;
        end else if (m_valid && rsp_ready) begin
            m_valid = 0;
        end
        @(negedge clk);
    endtask

    typedef struct {
        bit       who;
        bit [7:0] data;
        bit [2:0] srcw;
        bit       mode;
        bit [7:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        bit pend0, pend1, first_ack0;

        vecs[0] = '{0, 8'h0C, 3'd3, 1'b1, 8'hFC};
        vecs[1] = '{0, 8'hAC, 3'd3, 1'b0, 8'h0C};
        vecs[2] = '{1, 8'h80, 3'd7, 1'b1, 8'h80};
        vecs[3] = '{1, 8'h5A, 3'd7, 1'b0, 8'h5A};
        vecs[4] = '{0, 8'h01, 3'd0, 1'b1, 8'hFF};
        vecs[5] = '{1, 8'hFE, 3'd0, 1'b1, 8'h00};
        vecs[6] = '{0, 8'h7F, 3'd6, 1'b1, 8'hFF};
        vecs[7] = '{1, 8'hBF, 3'd6, 1'b0, 8'h3F};

        rst = 1; req0 = 0; req1 = 0; rsp_ready = 0;
        data0 = 0; data1 = 0; srcw0 = 0; srcw1 = 0; mode0 = 0; mode1 = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("reset rsp_valid", int'(rsp_valid), 0);
        chk("reset rsp_data", int'(rsp_data), 0);
        chk("reset rsp_id", int'(rsp_id), 0);
        chk("reset stall_cnt", int'(stall_cnt), 0);
        @(negedge clk);
        rst = 0;

        // single-requester extension vectors
        foreach (vecs[i]) begin
            rsp_ready = 1;
            if (vecs[i].who) begin
                req1 = 1; data1 = vecs[i].data; srcw1 = vecs[i].srcw; mode1 = vecs[i].mode;
            end else begin
                req0 = 1; data0 = vecs[i].data; srcw0 = vecs[i].srcw; mode0 = vecs[i].mode;
            end
            cycle();
            req0 = 0; req1 = 0; data0 = 8'h33; data1 = 8'h33;
            #1;
            chk($sformatf("vec%0d data", i), int'(rsp_data), int'(vecs[i].exp));
            chk($sformatf("vec%0d id", i), int'(rsp_id), int'(vecs[i].who));
            cycle();
            cycle();
        end

        // both requesters held: grants alternate, one result per cycle
        req0 = 1; req1 = 1; rsp_ready = 1;
        data0 = 8'h11; srcw0 = 7; data1 = 8'h22; srcw1 = 7;
        first_ack0 = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (i == 0) first_ack0 = ack0;
            chk($sformatf("alt%0d ack0", i), int'(ack0), int'(first_ack0 ^ bit'(i & 1)));
            cycle();
        end
        req0 = 0; req1 = 0;
        cycle();

        // long backpressure: result stable, pending request not acked, counter saturates
        req0 = 1; data0 = 8'h96; srcw0 = 4; mode0 = 1;
        cycle();
        rsp_ready = 0;
        req0 = 0; req1 = 1; data1 = 8'h05; srcw1 = 2; mode1 = 0;
        for (int i = 0; i < 300; i++) cycle();
        #1;
        chk("stall saturated", int'(stall_cnt), 255);
        chk("held data", int'(rsp_data), int'(ref_ext(8'h96, 4, 1)));
        rsp_ready = 1;
        cycle();
        req1 = 0;
        #1;
        chk("after stall id", int'(rsp_id), 1);
        cycle();
        cycle();
        #1;
        chk("delivered once", int'(rsp_valid), 0);

        // reset while a result is held
        req0 = 1; data0 = 8'h44; srcw0 = 7; rsp_ready = 0;
        cycle();
        cycle();
        #1;
        chk("pre-reset valid", int'(rsp_valid), 1);
        rst = 1;
        #1;
        chk("async rst valid", int'(rsp_valid), 0);
        chk("async rst stall", int'(stall_cnt), 0);
        chk("async rst ack0", int'(ack0), 0);
        model_reset();
        req0 = 0;
        @(negedge clk);
        rst = 0;
        req0 = 1; req1 = 1; rsp_ready = 1;
        #1;
        chk("post-reset contention ack0", int'(ack0), 1);
        cycle();
        req0 = 0; req1 = 0;
        cycle();
        cycle();

        // randomized traffic under the hold-until-ack protocol
        pend0 = 0; pend1 = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!pend0 && $urandom_range(0, 2) != 0) begin
                pend0 = 1; data0 = 8'($urandom); srcw0 = 3'($urandom); mode0 = 1'($urandom);
            end
            if (!pend1 && $urandom_range(0, 2) != 0) begin
                pend1 = 1; data1 = 8'($urandom); srcw1 = 3'($urandom); mode1 = 1'($urandom);
            end
            req0 = pend0; req1 = pend1;
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (e_ack0) pend0 = 0;
            if (e_ack1) pend1 = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ext_arbiter.md
EXT_ARBITER -- requirements
Module: ext_arbiter

Interface
REQ-001 Parameter: DATA_W, 8, width of operand and extended result.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst  input  1  asynchronous reset, active-high.
REQ-004 Port: req0 / req1  input  1  extension request from requester 0 (decode) / 1 (load unit).
REQ-005 Port: data0 / data1  input  DATA_W  raw operand, valid bits right-aligned.
REQ-006 Port: srcw0 / srcw1  input  3  number of valid source bits minus 1 (0..7 -> 1..8 bits).
REQ-007 Port: mode0 / mode1  input  1  0 = zero-extend, 1 = sign-extend.
REQ-008 Port: ack0 / ack1  output  1  request accepted this cycle (combinational).
REQ-009 Port: rsp_valid  output  1  result available.
REQ-010 Port: rsp_ready  input  1  consumer accepts result.
REQ-011 Port: rsp_data  output  DATA_W  extended result.
REQ-012 Port: rsp_id  output  1  requester index owning rsp_data.
REQ-013 Port: stall_cnt  output  8  saturating count of backpressure cycles.

Function
REQ-014 The block SHALL share one extension datapath between two requesters via a 2-state FSM: IDLE (no result held) and RESP (result held, rsp_valid=1).
REQ-015 The block SHALL accept a request when it can load: state IDLE, or state RESP with rsp_ready=1.
REQ-016 On a load cycle with any reqN=1, the block SHALL grant exactly one requester, assert its ackN for that cycle only, and register data/srcw/mode/id.
REQ-017 Arbitration SHALL be round-robin: if both request, grant the one not granted last; a single requester always wins.
REQ-018 The last-grant pointer SHALL reset to 1, so requester 0 wins the first contention.
REQ-019 ackN SHALL be 0 whenever reqN=0 or the block cannot load.
REQ-020 Requesters SHALL hold reqN, dataN, srcwN, modeN stable until ackN; the block SHALL NOT sample them otherwise.
REQ-021 Latency: rsp_valid SHALL rise on the clock edge after ack (1 cycle).
REQ-022 Extension: bits [srcw:0] of rsp_data SHALL equal the source bits; bits above srcw SHALL be 0 (mode 0) or copies of source bit srcw (mode 1).
REQ-023 Source bits above srcw SHALL be ignored regardless of value.
REQ-024 srcw=7 SHALL pass data unchanged in both modes.
REQ-025 rsp_data/rsp_id SHALL remain stable while rsp_valid=1 and rsp_ready=0.
REQ-026 RESP with rsp_ready=1 and no request SHALL go to IDLE, rsp_valid=0 next cycle.
REQ-027 RESP with rsp_ready=1 and a request SHALL ack in that cycle and stay in RESP with the new result next cycle (full throughput, one result per cycle).
REQ-028 IDLE with no request SHALL remain IDLE.
REQ-029 rsp_ready while rsp_valid=0 SHALL be ignored.
REQ-030 stall_cnt SHALL increment each cycle with rsp_valid=1 and rsp_ready=0, saturate at 255, and never wrap.

Reset
REQ-031 While rst=1, regardless of clk: state IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, stall_cnt=0, pointer=1; ack0/ack1 SHALL be 0.
REQ-032 Reset mid-operation SHALL discard any held result without delivering it.
REQ-033 After release, the first rising edge SHALL be able to accept a request.

Verification
REQ-034 req0, data0=8'b0000_1100, srcw0=3, mode0=1 -> ack0 same cycle; next cycle rsp_valid=1, rsp_data=8'hFC, rsp_id=0.
REQ-035 Same operand with mode0=0 and junk upper bits (data0=8'hAC) -> rsp_data=8'h0C.
REQ-036 req0 and req1 held every cycle, rsp_ready=1 -> grants alternate 0,1,0,1; one rsp per cycle; rsp_id follows.
REQ-037 Result held, rsp_ready=0 for 300 cycles -> rsp_data stable, no ack, stall_cnt=255; then rsp_ready=1 -> delivered once.
REQ-038 rst pulsed while rsp_valid=1 -> rsp_valid=0, stall_cnt=0 immediately; the next contention grants requester 0.
